pb_bus_master: RTL and testbench

PB_BUS_MASTER -- requirements
Module: pb_bus_master

---
 rtl/pb_bus_master.sv | 182 ++++++++++++++++++
 tb/tb_pb_bus_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pb_bus_master.sv
// ============================================================================
// Module  : pb_bus_master
// Brief   : Command/response front end that runs timed read/write cycles on a
//           strobed parallel peripheral bus. Optional macro: PB_READ_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_bus_master #(
   parameter int RESET_CYCLES  = 100,
   parameter int SETUP_CYCLES  = 4,
   parameter int STROBE_CYCLES = 8,
   parameter int HOLD_CYCLES   = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cmd_valid,
   input  logic       cmd_write,
   input  logic [2:0] cmd_addr,
   input  logic       cmd_test_addr,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_error,
   output logic [7:0] DataP,
   output logic       DataOeP,
   input  logic [7:0] DataInP,
   output logic [2:0] AddessP,
   output logic       TestAddressP,
   output logic       B0P,
   output logic       RdP,
   output logic       WrP,
   output logic       ResetP
);

   // A zero-length phase would never reach its terminal count, so clamp to 1.
   localparam logic [15:0] c_RESET_LEN  = (RESET_CYCLES  < 1) ? 16'd1 : 16'(RESET_CYCLES);
   localparam logic [15:0] c_SETUP_LEN  = (SETUP_CYCLES  < 1) ? 16'd1 : 16'(SETUP_CYCLES);
   localparam logic [15:0] c_STROBE_LEN = (STROBE_CYCLES < 1) ? 16'd1 : 16'(STROBE_CYCLES);
   localparam logic [15:0] c_HOLD_LEN   = (HOLD_CYCLES   < 1) ? 16'd1 : 16'(HOLD_CYCLES);

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      IDLE   = 3'd1,
      SETUP  = 3'd2,
      STROBE = 3'd3,
      HOLD   = 3'd4,
      RESP   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_phase_len;
   logic        w_last;
   logic        w_accept;

   logic [2:0]  r_addr;
   logic        r_test_addr;
   logic [7:0]  r_data;
   logic        r_write;
   logic [7:0]  r_rsp_data;
   logic        r_rsp_error;

   assign w_accept = cmd_valid && (r_state == IDLE);
   assign w_last   = (r_cnt == (w_phase_len - 16'd1));

   always_comb begin
      w_state_nxt = r_state;
      w_phase_len = 16'd1;
      case (r_state)
         INIT: begin
            w_phase_len = c_RESET_LEN;
            if (w_last) w_state_nxt = IDLE;
         end
         IDLE: begin
            if (cmd_valid) begin
`ifdef PB_READ_EN
               w_state_nxt = SETUP;
`else
               // Reads are rejected without touching the bus.
               w_state_nxt = cmd_write ? SETUP : RESP;
`endif
            end
         end
         SETUP: begin
            w_phase_len = c_SETUP_LEN;
            if (w_last) w_state_nxt = STROBE;
         end
         STROBE: begin
            w_phase_len = c_STROBE_LEN;
            if (w_last) w_state_nxt = HOLD;
         end
         HOLD: begin
            w_phase_len = c_HOLD_LEN;
            if (w_last) w_state_nxt = RESP;
         end
         RESP: begin
            if (rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= INIT;
         r_cnt   <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state)
            r_cnt <= 16'd0;
         else if (r_state != IDLE && r_state != RESP)
            r_cnt <= r_cnt + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr      <= 3'd0;
         r_test_addr <= 1'b0;
         r_data      <= 8'd0;
         r_write     <= 1'b0;
         r_rsp_data  <= 8'd0;
         r_rsp_error <= 1'b0;
      end else if (w_accept) begin
`ifdef PB_READ_EN
         r_addr      <= cmd_addr;
         r_test_addr <= cmd_test_addr;
         r_data      <= cmd_data;
         r_write     <= cmd_write;
         r_rsp_data  <= 8'h00;
         r_rsp_error <= 1'b0;
`else
         r_write     <= cmd_write;
         if (cmd_write) begin
            r_addr      <= cmd_addr;
            r_test_addr <= cmd_test_addr;
            r_data      <= cmd_data;
            r_rsp_data  <= 8'h00;
            r_rsp_error <= 1'b0;
         end else begin
            r_rsp_data  <= 8'hFF;
            r_rsp_error <= 1'b1;
         end
`endif
      end
`ifdef PB_READ_EN
      else if (r_state == STROBE && w_last && !r_write) begin
         r_rsp_data <= DataInP;
      end
`endif
   end

`ifndef PB_READ_EN
   logic w_unused;
   assign w_unused = ^DataInP;
`endif

   // Bus controls decode from state so reset removes them without a clock.
   assign ResetP       = (r_state == INIT);
   assign B0P          = (r_state != INIT);
   assign cmd_ready    = (r_state == IDLE);
   assign rsp_valid    = (r_state == RESP);
   assign WrP          = (r_state == STROBE) && r_write;
`ifdef PB_READ_EN
   assign RdP          = (r_state == STROBE) && !r_write;
`else
   assign RdP          = 1'b0;
`endif
   assign DataOeP      = r_write && (r_state == SETUP || r_state == STROBE || r_state == HOLD);
   assign DataP        = r_data;
   assign AddessP      = r_addr;
   assign TestAddressP = r_test_addr;
   assign rsp_data     = r_rsp_data;
   assign rsp_error    = r_rsp_error;

endmodule

`default_nettype wire

// File: tb/tb_pb_bus_master.sv
// ============================================================================
// Module  : tb_pb_bus_master
// Brief   : Directed scoreboard bench for pb_bus_master (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pb_bus_master;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       cmd_valid, cmd_write, cmd_test_addr;
   logic [2:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       rsp_valid, rsp_ready, rsp_error;
   logic [7:0] rsp_data;
   logic [7:0] DataP, DataInP;
   logic       DataOeP, TestAddressP, B0P, RdP, WrP, ResetP;
   logic [2:0] AddessP;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [8:0] sb[$];
   logic [2:0] last_addr = 3'd0;

   pb_bus_master dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_test_addr(cmd_test_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_error(rsp_error), .DataP(DataP), .DataOeP(DataOeP), .DataInP(DataInP),
      .AddessP(AddessP), .TestAddressP(TestAddressP), .B0P(B0P), .RdP(RdP),
      .WrP(WrP), .ResetP(ResetP)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Release reset on a negedge and watch the bus-reset phase.
   task automatic init_seq();
      int bad_rst, bad_rdy, bad_rsp;
      bad_rst = 0; bad_rdy = 0; bad_rsp = 0;
      reset_n = 1'b1;
      for (int k = 1; k < 100; k++) begin
         @(negedge clock);
         if (ResetP !== 1'b1 || B0P !== 1'b0) bad_rst++;
         if (cmd_ready !== 1'b0) bad_rdy++;
         if (rsp_valid !== 1'b0) bad_rsp++;
      end
      @(negedge clock);
      chk("init_resetp_held", bad_rst, 0);
      chk("init_no_ready", bad_rdy, 0);
      chk("init_no_rsp", bad_rsp, 0);
      chk("init_done_resetp", ResetP, 0);
      chk("init_done_b0p", B0P, 1);
      chk("init_done_ready", cmd_ready, 1);
   endtask

   // Caller is on a negedge with the DUT in IDLE.
   task automatic do_cmd(input logic wr, input logic [2:0] a, input logic ta,
                         input logic [7:0] d, input int hold);
      bit         exec;
      int         k, t_stb, n_stb, t_rsp, bad_oe, bad_stb, bad_hold, bad_rdy, exp_rsp_k;
      logic [8:0] exp_r;
      logic [8:0] got;
      logic [2:0] addr_after;
`ifdef PB_READ_EN
      exec = 1'b1;
`else
      exec = wr;
`endif
      if (wr)        exp_r = {8'h00, 1'b0};
      else if (exec) exp_r = {DataInP, 1'b0};
      else           exp_r = {8'hFF, 1'b1};
      exp_rsp_k = exec ? 17 : 1;
      sb.push_back(exp_r);

      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_test_addr = ta; cmd_data = d;
      k = 0; t_stb = -1; n_stb = 0; t_rsp = -1; bad_oe = 0; bad_stb = 0;
      while (t_rsp < 0 && k < 60) begin
         @(negedge clock);
         k++;
         if (k == 1) begin
            cmd_valid = 1'b0;
            chk("addr_driven", AddessP, exec ? a : last_addr);
            if (exec) chk("testaddr_driven", TestAddressP, ta);
            if (wr) chk("data_driven", DataP, d);
         end
         if (RdP && WrP) bad_stb++;
         if (wr ? RdP : WrP) bad_stb++;
         if (wr ? WrP : RdP) begin
            if (t_stb < 0) t_stb = k;
            n_stb++;
         end
         if (DataOeP !== (wr && k < exp_rsp_k)) bad_oe++;
         if (rsp_valid === 1'b1) t_rsp = k;
      end
      chk("rsp_latency", t_rsp, exp_rsp_k);
      chk("strobe_len", n_stb, exec ? 8 : 0);
      if (exec) chk("strobe_start", t_stb, 5);
      chk("strobe_exclusive", bad_stb, 0);
      chk("data_oe", bad_oe, 0);
      if (exec) last_addr = a;

      chk("sb_nonempty", sb.size(), 1);
      if (sb.size() > 0) begin
         exp_r = sb.pop_front();
         chk("rsp_data", rsp_data, exp_r[8:1]);
         chk("rsp_error", rsp_error, exp_r[0]);
      end

      got = {rsp_data, rsp_error};
      bad_hold = 0; bad_rdy = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         if (rsp_valid !== 1'b1 || {rsp_data, rsp_error} !== got) bad_hold++;
         if (cmd_ready !== 1'b0) bad_rdy++;
         cmd_valid = (i == 5);
         cmd_write = 1'b1; cmd_addr = ~a; cmd_data = ~d;
      end
      cmd_valid = 1'b0;
      if (hold > 0) begin
         chk("rsp_hold_stable", bad_hold, 0);
         chk("rsp_hold_no_ready", bad_rdy, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      chk("rsp_released", rsp_valid, 0);
      chk("back_idle", cmd_ready, 1);
      addr_after = AddessP;
      repeat (3) @(negedge clock);
      chk("no_queued_cmd", {rsp_valid, cmd_ready, AddessP}, {1'b0, 1'b1, addr_after});
   endtask

   initial begin
      int n;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 3'd0;
      cmd_test_addr = 1'b0; cmd_data = 8'd0; rsp_ready = 1'b0; DataInP = 8'h00;
      repeat (3) @(negedge clock);
      chk("rst_resetp_b0p", {ResetP, B0P}, 2'b10);
      chk("rst_strobes", {RdP, WrP, DataOeP}, 3'b000);
      chk("rst_bus", {DataP, AddessP, TestAddressP}, 12'h000);
      chk("rst_handshake", {cmd_ready, rsp_valid}, 2'b00);
      chk("rst_rsp", {rsp_data, rsp_error}, 9'h000);

      init_seq();
      do_cmd(1'b1, 3'b101, 1'b1, 8'hA5, 0);
      do_cmd(1'b1, 3'b011, 1'b0, 8'h5A, 20);
      DataInP = 8'h3C;
      do_cmd(1'b0, 3'b010, 1'b0, 8'h00, 20);
      DataInP = 8'hC3;
      do_cmd(1'b1, 3'b111, 1'b0, 8'hFF, 2);

      // Abort a write mid-strobe; no response may follow.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'b110; cmd_data = 8'h96;
      n = 0;
      do begin
         @(negedge clock);
         cmd_valid = 1'b0;
         n++;
      end while (WrP !== 1'b1 && n < 20);
      chk("abort_strobe_seen", WrP, 1);
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_wrp_async", WrP, 0);
      chk("abort_resetp", {ResetP, B0P, DataOeP, AddessP}, 6'b100000);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (rsp_valid !== 1'b0) n++;
      end
      chk("abort_no_rsp", n, 0);
      init_seq();
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
